// File: rtl/booth_mul_iter.sv
// booth_mul_iter: iterative radix-4 Booth multiplier with a start/busy/done
// handshake and a synchronous cancel.
//   Parameters: WIDTH (operand width, even, >= 4); PP_PER_CYCLE (1 or 2).
//   Inputs:  clk, rst (sync, active-high), start, signed_op, a, b, cancel.
//   Outputs: busy, done (one-cycle pulse), result (2*WIDTH, held until the
//            next completion).
//   Optional: BOOTH_ZERO_SKIP_EN returns 0 one cycle after start when an
//             operand is zero; CALC is skipped and busy stays 0.
module booth_mul_iter #(
  parameter int WIDTH        = 32,
  parameter int PP_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int N_PP = WIDTH / 2 + 1;
  localparam int C    = (N_PP + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
  localparam int CW   = $clog2(C + 1);
  localparam int AW   = 2 * WIDTH + 2;
  localparam int YW   = WIDTH + 3;
  localparam int SH   = 2 * PP_PER_CYCLE;

  localparam logic [CW-1:0] LAST = CW'(C - 1);
  // With two PPs per cycle and an odd PP count, the last slot is padding.
  localparam bit PAD = (PP_PER_CYCLE == 2) && (N_PP % 2 == 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] mcand;
  logic [YW-1:0] yw;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;

  logic [AW-1:0] acc_next;
  logic [2:0]    win;
  logic [AW-1:0] m;
  logic [AW-1:0] pp;
  logic          neg;
  logic          xs;
  logic          ys;
  logic          skip;

  assign busy = (state == CALC);
  assign xs   = signed_op & a[WIDTH-1];
  assign ys   = signed_op & b[WIDTH-1];

`ifdef BOOTH_ZERO_SKIP_EN
  assign skip = (a == '0) || (b == '0);
`else
  assign skip = 1'b0;
`endif

  // mcand is X sign-extended and pre-shifted to the current PP position;
  // yw holds {Y, Y[-1]} shifted so the current window sits at yw[2:0].
  always_comb begin
    acc_next = acc;
    win      = '0;
    m        = '0;
    pp       = '0;
    neg      = 1'b0;
    for (int j = 0; j < PP_PER_CYCLE; j++) begin
      win = yw[2*j +: 3];
      m   = mcand << (2 * j);
      pp  = '0;
      neg = 1'b0;
      unique case (win)
        3'b001, 3'b010: pp = m;
        3'b011:         pp = m << 1;
        3'b100: begin
          pp  = ~(m << 1);
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          pp  = ~m;
          neg = 1'b1;
        end
        default:        pp = '0;
      endcase
      if (PAD && j == 1 && cnt == LAST) begin
        pp  = '0;
        neg = 1'b0;
      end
      acc_next = acc_next + pp + AW'(neg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      yw     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && skip) begin
            done   <= 1'b1;
            result <= '0;
          end else if (start) begin
            mcand <= {{(WIDTH + 2){xs}}, a};
            yw    <= {ys, ys, b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            acc   <= acc_next;
            mcand <= mcand << SH;
            yw    <= YW'($signed(yw) >>> SH);
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
              result <= acc_next[2*WIDTH-1:0];
              done   <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_iter.sv
// tb_booth_mul_iter: scoreboard bench for booth_mul_iter with P=1 and P=2
// instances driven by the same directed vectors.
module tb_booth_mul_iter;

  localparam int W = 32;

`ifdef BOOTH_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signed_op;
  logic          cancel;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy1, done1, busy2, done2;
  logic [2*W-1:0] res1, res2;

  typedef struct {
    logic [63:0] exp;
    int          s_edge;
    int          edges;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  booth_mul_iter #(.WIDTH(W), .PP_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .cancel(cancel),
    .busy(busy1), .done(done1), .result(res1)
  );

  booth_mul_iter #(.WIDTH(W), .PP_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .cancel(cancel),
    .busy(busy2), .done(done2), .result(res2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL p1_unexpected_done: got done=1 expected done=0");
      end else begin
        e = q1.pop_front();
        chk("p1_result", res1, e.exp);
        chk("p1_latency_edges", 64'(cyc - e.s_edge), 64'(e.edges));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL p2_unexpected_done: got done=1 expected done=0");
      end else begin
        e = q2.pop_front();
        chk("p2_result", res2, e.exp);
        chk("p2_latency_edges", 64'(cyc - e.s_edge), 64'(e.edges));
      end
    end
  end

  // Called at a falling edge; start is sampled at the next rising edge.
  task automatic issue(input bit sg, input logic [31:0] x,
                       input logic [31:0] y, input bit push,
                       input logic [63:0] exp);
    exp_t e;
    bit   z;
    signed_op = sg;
    a         = x;
    b         = y;
    start     = 1'b1;
    if (push) begin
      z        = ZS && (x == 0 || y == 0);
      e.exp    = exp;
      e.s_edge = cyc + 1;
      e.edges  = z ? 0 : 17;
      q1.push_back(e);
      e.edges  = z ? 0 : 9;
      q2.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!busy1 && !busy2 && q1.size() == 0 && q2.size() == 0)
        ok = 1'b1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got busy1=%0d busy2=%0d expected idle",
               busy1, busy2);
      q1.delete();
      q2.delete();
    end
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    start     = 1'b0;
    cancel    = 1'b0;
    signed_op = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy1", 64'(busy1), 64'd0);
    chk("reset_busy2", 64'(busy2), 64'd0);
    chk("reset_done1", 64'(done1), 64'd0);
    chk("reset_res1", res1, 64'd0);
    chk("reset_res2", res2, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'h0000_0000_0000_0001);
    wait_idle();
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001);
    wait_idle();
    issue(1, 32'h8000_0000, 32'h7FFF_FFFF, 1, 64'hC000_0000_8000_0000);
    wait_idle();
    issue(1, 32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000);
    wait_idle();

    // Cancel sampled five edges after start; nothing may complete.
    issue(0, 32'd3, 32'd5, 0, 64'd0);
    repeat (4) @(negedge clk);
    chk("cancel_pre_busy1", 64'(busy1), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy1", 64'(busy1), 64'd0);
    chk("cancel_busy2", 64'(busy2), 64'd0);
    repeat (20) @(negedge clk);
    chk("cancel_hold_res1", res1, 64'h4000_0000_0000_0000);
    chk("cancel_hold_res2", res2, 64'h4000_0000_0000_0000);

    issue(0, 32'd3, 32'd5, 1, 64'h0000_0000_0000_000F);
    wait_idle();

    // Second start lands in the P=1 done cycle.
    issue(0, 32'h0001_0000, 32'h0001_0000, 1, 64'h0000_0001_0000_0000);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL b2b_timeout: got no done1 expected done1 within 30");
    end
    issue(1, 32'd7, 32'hFFFF_FFFE, 1, 64'hFFFF_FFFF_FFFF_FFF2);
    wait_idle();

    // Reset during CALC: cycle 8 of the operation.
    issue(0, 32'd3, 32'd5, 1, 64'h0000_0000_0000_000F);
    repeat (6) @(negedge clk);
    chk("rst_pre_busy2", 64'(busy2), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q1.delete();
    q2.delete();
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_busy2", 64'(busy2), 64'd0);
    chk("rst_done1", 64'(done1), 64'd0);
    chk("rst_res1", res1, 64'd0);
    chk("rst_res2", res2, 64'd0);
    repeat (20) @(negedge clk);

    issue(1, 32'd9, 32'd9, 1, 64'd81);
    wait_idle();
    issue(0, 32'd0, 32'h1234_5678, 1, 64'd0);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
